// File: rtl/axi_isolate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_isolate_pkg                                                      |
// | Shared state encoding and defaults for the AXI drain/isolate block.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package axi_isolate_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ISOLATED = 2'd2
    } state_e;

    localparam int c_MAX_TXNS_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/axi_txn_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_txn_counter                                                      |
// | Outstanding-transaction up/down counter with full and underflow.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_txn_counter #(
    parameter int MAX_CNT = 8,
    parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_full,
    output logic             o_underflow
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero      = (r_cnt == '0);
    // A lone decrement at zero is a protocol violation; the count holds at zero.
    assign o_underflow = i_dec & ~i_inc & w_zero;
    assign o_full      = (r_cnt >= c_MAX);
    assign o_cnt       = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc & ~i_dec) begin
            r_cnt <= r_cnt + c_ONE;
        end else if (i_dec & ~i_inc & ~w_zero) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_isolate_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_isolate_drain                                                    |
// | Blocks new AW/AR on request, drains W/B/R, then asserts isolate_o.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_isolate_drain
    import axi_isolate_pkg::*;
#(
    parameter int MAX_TXNS = c_MAX_TXNS_DEFAULT,
    parameter int CNT_W    = $clog2(MAX_TXNS + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic isolate_req_i,
    output logic isolate_o,
    output logic draining_o,
    output logic protocol_err_o,

    input  logic s_aw_valid_i,
    output logic s_aw_ready_o,
    output logic m_aw_valid_o,
    input  logic m_aw_ready_i,

    input  logic s_w_valid_i,
    input  logic s_w_last_i,
    output logic s_w_ready_o,
    output logic m_w_valid_o,
    input  logic m_w_ready_i,

    input  logic s_ar_valid_i,
    output logic s_ar_ready_o,
    output logic m_ar_valid_o,
    input  logic m_ar_ready_i,

    input  logic m_b_valid_i,
    output logic m_b_ready_o,
    output logic s_b_valid_o,
    input  logic s_b_ready_i,

    input  logic m_r_valid_i,
    input  logic m_r_last_i,
    output logic m_r_ready_o,
    output logic s_r_valid_o,
    input  logic s_r_ready_i
);

    state_e           r_state;
    logic             r_isolate;
    logic             r_draining;
    logic             r_protocol_err;
    logic             r_aw_hold;
    logic             r_ar_hold;

    logic [CNT_W-1:0] w_wr_cnt;
    logic [CNT_W-1:0] w_rd_cnt;
    logic [CNT_W-1:0] w_w_pend;
    logic             w_wr_full;
    logic             w_rd_full;
    logic             w_wp_full;
    logic             w_wr_unf;
    logic             w_rd_unf;
    logic             w_wp_unf;

    logic             w_run;
    logic             w_aw_allow;
    logic             w_ar_allow;
    logic             w_w_allow;
    logic             w_aw_hs;
    logic             w_ar_hs;
    logic             w_w_last_hs;
    logic             w_b_hs;
    logic             w_r_last_hs;
    logic             w_quiet;

    assign w_run      = (r_state == ST_RUN);
    // A held address bypasses the state check so a presented valid is never retracted.
    assign w_aw_allow = (w_run & ~w_wr_full & ~w_wp_full) | r_aw_hold;
    assign w_ar_allow = (w_run & ~w_rd_full) | r_ar_hold;
    assign w_w_allow  = (w_w_pend != '0);

    assign m_aw_valid_o = s_aw_valid_i & w_aw_allow;
    assign s_aw_ready_o = m_aw_ready_i & w_aw_allow;
    assign m_ar_valid_o = s_ar_valid_i & w_ar_allow;
    assign s_ar_ready_o = m_ar_ready_i & w_ar_allow;
    assign m_w_valid_o  = s_w_valid_i & w_w_allow;
    assign s_w_ready_o  = m_w_ready_i & w_w_allow;

    assign s_b_valid_o  = m_b_valid_i;
    assign m_b_ready_o  = s_b_ready_i;
    assign s_r_valid_o  = m_r_valid_i;
    assign m_r_ready_o  = s_r_ready_i;

    assign w_aw_hs      = m_aw_valid_o & m_aw_ready_i;
    assign w_ar_hs      = m_ar_valid_o & m_ar_ready_i;
    assign w_w_last_hs  = m_w_valid_o & m_w_ready_i & s_w_last_i;
    assign w_b_hs       = s_b_valid_o & s_b_ready_i;
    assign w_r_last_hs  = s_r_valid_o & s_r_ready_i & m_r_last_i;

    assign w_quiet = (w_wr_cnt == '0) & (w_rd_cnt == '0) & (w_w_pend == '0) &
                     ~r_aw_hold & ~r_ar_hold & ~m_b_valid_i & ~m_r_valid_i;

    axi_txn_counter #(.MAX_CNT(MAX_TXNS), .CNT_W(CNT_W)) u_wr_cnt (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_inc      (w_aw_hs),
        .i_dec      (w_b_hs),
        .o_cnt      (w_wr_cnt),
        .o_full     (w_wr_full),
        .o_underflow(w_wr_unf)
    );

    axi_txn_counter #(.MAX_CNT(MAX_TXNS), .CNT_W(CNT_W)) u_rd_cnt (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_inc      (w_ar_hs),
        .i_dec      (w_r_last_hs),
        .o_cnt      (w_rd_cnt),
        .o_full     (w_rd_full),
        .o_underflow(w_rd_unf)
    );

    axi_txn_counter #(.MAX_CNT(MAX_TXNS), .CNT_W(CNT_W)) u_w_pend (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_inc      (w_aw_hs),
        .i_dec      (w_w_last_hs),
        .o_cnt      (w_w_pend),
        .o_full     (w_wp_full),
        .o_underflow(w_wp_unf)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aw_hold      <= 1'b0;
            r_ar_hold      <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_hold <= 1'b0;
            end else if (m_aw_valid_o) begin
                r_aw_hold <= 1'b1;
            end
            if (w_ar_hs) begin
                r_ar_hold <= 1'b0;
            end else if (m_ar_valid_o) begin
                r_ar_hold <= 1'b1;
            end
            if (w_wr_unf | w_rd_unf | w_wp_unf) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_isolate  <= 1'b0;
            r_draining <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (isolate_req_i) begin
                        r_state    <= ST_DRAIN;
                        r_draining <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!isolate_req_i) begin
                        r_state    <= ST_RUN;
                        r_draining <= 1'b0;
                    end else if (w_quiet) begin
                        r_state    <= ST_ISOLATED;
                        r_draining <= 1'b0;
                        r_isolate  <= 1'b1;
                    end
                end
                ST_ISOLATED: begin
                    if (!isolate_req_i) begin
                        r_state   <= ST_RUN;
                        r_isolate <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_isolate  <= 1'b0;
                    r_draining <= 1'b0;
                end
            endcase
        end
    end

    assign isolate_o      = r_isolate;
    assign draining_o     = r_draining;
    assign protocol_err_o = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_isolate_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_isolate_drain                                                 |
// | Directed self-checking bench for axi_isolate_drain.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_axi_isolate_drain;

    logic clk, rst, req;
    logic aw_v, aw_rdy_m, w_v, w_last, w_rdy_m, ar_v, ar_rdy_m;
    logic b_v_m, b_rdy_s, r_v_m, r_last, r_rdy_s;
    logic iso, drn, perr, s_aw_rdy, m_aw_v, s_w_rdy, m_w_v, s_ar_rdy, m_ar_v;
    logic m_b_rdy, s_b_v, m_r_rdy, s_r_v;

    // Second instance with MAX_TXNS=2, exercised only on the read side.
    logic q_ar_v, q_ar_rdy, q_r_v, q_r_last, q_r_rdy;
    logic q_iso, q_drn, q_perr, q_s_aw_rdy, q_m_aw_v, q_s_w_rdy, q_m_w_v;
    logic q_s_ar_rdy, q_m_ar_v, q_m_b_rdy, q_s_b_v, q_m_r_rdy, q_s_r_v;
    logic zero;

    int checks = 0;
    int failures = 0;

    axi_isolate_drain dut (
        .clk_i(clk), .rst_i(rst), .isolate_req_i(req),
        .isolate_o(iso), .draining_o(drn), .protocol_err_o(perr),
        .s_aw_valid_i(aw_v), .s_aw_ready_o(s_aw_rdy),
        .m_aw_valid_o(m_aw_v), .m_aw_ready_i(aw_rdy_m),
        .s_w_valid_i(w_v), .s_w_last_i(w_last), .s_w_ready_o(s_w_rdy),
        .m_w_valid_o(m_w_v), .m_w_ready_i(w_rdy_m),
        .s_ar_valid_i(ar_v), .s_ar_ready_o(s_ar_rdy),
        .m_ar_valid_o(m_ar_v), .m_ar_ready_i(ar_rdy_m),
        .m_b_valid_i(b_v_m), .m_b_ready_o(m_b_rdy),
        .s_b_valid_o(s_b_v), .s_b_ready_i(b_rdy_s),
        .m_r_valid_i(r_v_m), .m_r_last_i(r_last), .m_r_ready_o(m_r_rdy),
        .s_r_valid_o(s_r_v), .s_r_ready_i(r_rdy_s)
    );

    axi_isolate_drain #(.MAX_TXNS(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .isolate_req_i(zero),
        .isolate_o(q_iso), .draining_o(q_drn), .protocol_err_o(q_perr),
        .s_aw_valid_i(zero), .s_aw_ready_o(q_s_aw_rdy),
        .m_aw_valid_o(q_m_aw_v), .m_aw_ready_i(zero),
        .s_w_valid_i(zero), .s_w_last_i(zero), .s_w_ready_o(q_s_w_rdy),
        .m_w_valid_o(q_m_w_v), .m_w_ready_i(zero),
        .s_ar_valid_i(q_ar_v), .s_ar_ready_o(q_s_ar_rdy),
        .m_ar_valid_o(q_m_ar_v), .m_ar_ready_i(q_ar_rdy),
        .m_b_valid_i(zero), .m_b_ready_o(q_m_b_rdy),
        .s_b_valid_o(q_s_b_v), .s_b_ready_i(zero),
        .m_r_valid_i(q_r_v), .m_r_last_i(q_r_last), .m_r_ready_o(q_m_r_rdy),
        .s_r_valid_o(q_s_r_v), .s_r_ready_i(q_r_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        zero = 1'b0;
        rst = 1'b1; req = 1'b0;
        aw_v = 0; aw_rdy_m = 0; w_v = 0; w_last = 0; w_rdy_m = 0; ar_v = 0; ar_rdy_m = 0;
        b_v_m = 0; b_rdy_s = 0; r_v_m = 0; r_last = 0; r_rdy_s = 0;
        q_ar_v = 0; q_ar_rdy = 0; q_r_v = 0; q_r_last = 0; q_r_rdy = 0;
        #2;
        chk("rst_iso", {31'd0, iso}, 0);
        chk("rst_drn", {31'd0, drn}, 0);
        chk("rst_perr", {31'd0, perr}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: idle isolation
        req = 1'b1; settle();
        chk("t1_drn_c0", {31'd0, drn}, 0);
        tick();
        chk("t1_drn_c1", {31'd0, drn}, 1);
        chk("t1_iso_c1", {31'd0, iso}, 0);
        tick();
        chk("t1_iso_c2", {31'd0, iso}, 1);
        chk("t1_drn_c2", {31'd0, drn}, 0);
        aw_v = 1; aw_rdy_m = 1; ar_v = 1; ar_rdy_m = 1; settle();
        chk("t1_awv_blk", {31'd0, m_aw_v}, 0);
        chk("t1_arv_blk", {31'd0, m_ar_v}, 0);
        chk("t1_awr_blk", {31'd0, s_aw_rdy}, 0);
        aw_v = 0; ar_v = 0; req = 0;
        tick();
        chk("t1_iso_rel", {31'd0, iso}, 0);

        // 2: two write bursts drain before isolation
        aw_v = 1; settle();
        chk("t2_aw0_fwd", {31'd0, m_aw_v}, 1);
        tick(); settle();
        chk("t2_aw1_fwd", {31'd0, m_aw_v}, 1);
        tick();
        aw_v = 0; req = 1;
        tick();
        aw_v = 1; settle();
        chk("t2_drn", {31'd0, drn}, 1);
        chk("t2_aw_blk", {31'd0, m_aw_v}, 0);
        chk("t2_awr_blk", {31'd0, s_aw_rdy}, 0);
        w_v = 1; w_rdy_m = 1;
        for (int i = 0; i < 8; i++) begin
            w_last = (i == 3 || i == 7);
            settle();
            chk($sformatf("t2_w%0d_fwd", i), {31'd0, m_w_v}, 1);
            tick();
        end
        w_last = 0; settle();
        chk("t2_w_extra_blk", {31'd0, m_w_v}, 0);
        w_v = 0;
        b_v_m = 1; b_rdy_s = 1; settle();
        chk("t2_b_fwd", {31'd0, s_b_v}, 1);
        chk("t2_b_rdy", {31'd0, m_b_rdy}, 1);
        tick();
        chk("t2_iso_b1", {31'd0, iso}, 0);
        tick();
        b_v_m = 0; settle();
        chk("t2_iso_b2", {31'd0, iso}, 0);
        tick();
        chk("t2_iso_rise", {31'd0, iso}, 1);
        aw_v = 0; b_rdy_s = 0; req = 0;
        tick();

        // 3: address presented but stalled when isolation requested
        aw_v = 1; aw_rdy_m = 0; req = 1; settle();
        chk("t3_awv_run", {31'd0, m_aw_v}, 1);
        tick();
        chk("t3_awv_hold0", {31'd0, m_aw_v}, 1);
        chk("t3_drn", {31'd0, drn}, 1);
        tick();
        chk("t3_awv_hold1", {31'd0, m_aw_v}, 1);
        aw_rdy_m = 1; settle();
        chk("t3_awr_hold", {31'd0, s_aw_rdy}, 1);
        tick();
        chk("t3_aw_regated", {31'd0, m_aw_v}, 0);
        aw_v = 0;
        w_v = 1; w_last = 1; w_rdy_m = 1; settle();
        chk("t3_w_fwd", {31'd0, m_w_v}, 1);
        tick();
        w_v = 0; w_last = 0;
        tick(); tick();
        chk("t3_iso_wait_b", {31'd0, iso}, 0);
        b_v_m = 1; b_rdy_s = 1;
        tick();
        b_v_m = 0; settle();
        chk("t3_iso_b", {31'd0, iso}, 0);
        tick();
        chk("t3_iso_rise", {31'd0, iso}, 1);
        b_rdy_s = 0; req = 0;
        tick();

        // 4: MAX_TXNS=2 read limit
        q_ar_v = 1; q_ar_rdy = 1; settle();
        chk("t4_ar0_rdy", {31'd0, q_s_ar_rdy}, 1);
        tick();
        chk("t4_ar1_rdy", {31'd0, q_s_ar_rdy}, 1);
        tick();
        chk("t4_ar2_blk_rdy", {31'd0, q_s_ar_rdy}, 0);
        chk("t4_ar2_blk_v", {31'd0, q_m_ar_v}, 0);
        q_r_v = 1; q_r_last = 0; q_r_rdy = 1;
        tick();
        chk("t4_blk_nonlast", {31'd0, q_s_ar_rdy}, 0);
        q_r_last = 1; settle();
        chk("t4_blk_lastcyc", {31'd0, q_s_ar_rdy}, 0);
        tick();
        q_r_v = 0; q_r_last = 0; settle();
        chk("t4_ar2_rdy", {31'd0, q_s_ar_rdy}, 1);
        tick();
        chk("t4_full_again", {31'd0, q_s_ar_rdy}, 0);
        q_ar_v = 0;
        chk("t4_no_perr", {31'd0, q_perr}, 0);

        // 5: aborted drain with a read outstanding
        ar_v = 1; ar_rdy_m = 1;
        tick();
        ar_v = 0; req = 1;
        tick();
        chk("t5_drn", {31'd0, drn}, 1);
        tick();
        chk("t5_iso_a", {31'd0, iso}, 0);
        tick();
        chk("t5_iso_b", {31'd0, iso}, 0);
        req = 0;
        tick();
        chk("t5_run_drn", {31'd0, drn}, 0);
        chk("t5_run_iso", {31'd0, iso}, 0);
        ar_v = 1; settle();
        chk("t5_ar_fwd", {31'd0, m_ar_v}, 1);
        chk("t5_ar_rdy", {31'd0, s_ar_rdy}, 1);
        tick();
        ar_v = 0;
        r_v_m = 1; r_last = 1; r_rdy_s = 1; settle();
        chk("t5_r_fwd", {31'd0, s_r_v}, 1);
        chk("t5_r_rdy", {31'd0, m_r_rdy}, 1);
        tick(); tick();
        r_v_m = 0; r_last = 0; r_rdy_s = 0;
        chk("t5_no_perr", {31'd0, perr}, 0);

        // 6: stray B response
        b_v_m = 1; b_rdy_s = 1;
        tick();
        b_v_m = 0; b_rdy_s = 0; settle();
        chk("t6_perr_set", {31'd0, perr}, 1);
        tick();
        chk("t6_perr_sticky", {31'd0, perr}, 1);
        req = 1;
        tick(); tick();
        chk("t6_iso_cnt0", {31'd0, iso}, 1);
        req = 0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_perr_async_clr", {31'd0, perr}, 0);
        chk("t6_iso_async_clr", {31'd0, iso}, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
